// File: rtl/alu_exec_ctrl_pkg.sv
// exec_pkg: shared types for the EX-stage ALU control/execute block.
// Control codes, ALUOp constants, FSM states and the base funct decode.
package exec_pkg;

  localparam int ALU_CTRL_W = 5;

  typedef enum logic [ALU_CTRL_W-1:0] {
    AC_AND    = 5'b00000,
    AC_OR     = 5'b00001,
    AC_ADD    = 5'b00010,
    AC_XOR    = 5'b00011,
    AC_SRL    = 5'b00100,
    AC_SLTU   = 5'b00101,
    AC_SUB    = 5'b00110,
    AC_SLT    = 5'b01000,
    AC_SLL    = 5'b01001,
    AC_SRA    = 5'b01010,
    AC_MUL    = 5'b10000,
    AC_MULH   = 5'b10001,
    AC_MULHSU = 5'b10010,
    AC_MULHU  = 5'b10011,
    AC_DIV    = 5'b10100,
    AC_DIVU   = 5'b10101,
    AC_REM    = 5'b10110,
    AC_REMU   = 5'b10111
  } alu_ctrl_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_ADD2  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SINGLE,
    MUL,
    DIV,
    DONE
  } state_e;

  function automatic alu_ctrl_e funct_dec(
    input logic [2:0] f3,
    input logic       b30,
    input logic       b5
  );
    alu_ctrl_e c;
    c = AC_ADD;
    unique case (f3)
      3'b000: c = (b30 && b5) ? AC_SUB : AC_ADD;
      3'b001: c = AC_SLL;
      3'b010: c = AC_SLT;
      3'b011: c = AC_SLTU;
      3'b100: c = AC_XOR;
      3'b101: c = b30 ? AC_SRA : AC_SRL;
      3'b110: c = AC_OR;
      3'b111: c = AC_AND;
      default: c = AC_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: operand request and result handshakes of the EX ALU.
// master = pipeline side, slave = alu_exec_ctrl.
interface alu_exec_ctrl_if #(
  parameter int XLEN = 32
);
  import exec_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           instr;
  logic [1:0]            alu_op;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       result;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  illegal;

  modport master (
    output in_valid, instr, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, alu_ctrl, illegal
  );

  modport slave (
    input  in_valid, instr, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, alu_ctrl, illegal
  );

endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: shift-add multiplier / restoring divider on shared hi/lo regs.
// Works on magnitudes; signs are applied in the combinational final step.
module mdu_iter #(
  parameter int XLEN      = 32,
  parameter int MUL_RADIX = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic            is_div,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int R  = MUL_RADIX;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / R - 1);

  logic            busy, div_q, hi_q, neg_q, nega_q;
  logic [XLEN-1:0] hi, lo, dvs, hi_nxt, lo_nxt;
  logic [CW-1:0]   cnt;
  logic            sa, sb, na, nb;
  logic [XLEN-1:0] ma, mb;

  logic [XLEN+R-1:0] pp;
  logic [XLEN+R:0]   sum;
  logic [2*XLEN-1:0] wide, prod;
  logic [XLEN:0]     sh, diff;

  assign sa = is_div ? !fn[0] : (fn == 3'b001 || fn == 3'b010);
  assign sb = is_div ? !fn[0] : (fn == 3'b001);
  assign na = sa && a[XLEN-1];
  assign nb = sb && b[XLEN-1];
  assign ma = na ? -a : a;
  assign mb = nb ? -b : b;
  assign done = busy && (cnt == '0);

  always_comb begin
    pp   = (XLEN+R)'(dvs) * (XLEN+R)'(lo[R-1:0]);
    sum  = (XLEN+R+1)'(hi) + (XLEN+R+1)'(pp);
    wide = (2*XLEN)'({sum, lo} >> R);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, dvs};
    if (div_q) begin
      hi_nxt = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], !diff[XLEN]};
    end else begin
      hi_nxt = wide[2*XLEN-1:XLEN];
      lo_nxt = wide[XLEN-1:0];
    end
  end

  // Result is formed from the last step's value so done needs no extra cycle
  always_comb begin
    prod = {hi_nxt, lo_nxt};
    if (neg_q) prod = -prod;
    if (div_q) begin
      if (hi_q) res = nega_q ? -hi_nxt : hi_nxt;
      else      res = neg_q ? -lo_nxt : lo_nxt;
    end else begin
      res = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      neg_q  <= 1'b0;
      nega_q <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dvs    <= '0;
      cnt    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      div_q  <= is_div;
      hi_q   <= is_div ? fn[1] : (fn != 3'b000);
      neg_q  <= na ^ nb;
      nega_q <= na;
      hi     <= '0;
      lo     <= ma;
      dvs    <= mb;
      cnt    <= is_div ? DIV_LAST : MUL_LAST;
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt - CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: EX-stage ALU control decode, single-cycle ALU, result hold.
// Define MDU_EN to build the iterative RV32M multiply/divide path.
module alu_exec_ctrl
  import exec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MUL_RADIX = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  alu_exec_ctrl_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state, state_nxt;
  alu_ctrl_e       dec, ctrl_q;
  logic            dec_ill, ill_q;
  logic [XLEN-1:0] res_q, alu_res, single_res, mdu_res;
  logic [2:0]      f3;
  logic [SHW-1:0]  shamt;
  logic            is_funct, m_enc;
  logic            out_valid, in_ready, accept;
  logic            go_mul, go_div, mdu_done;

  assign f3       = bus.instr[14:12];
  assign shamt    = bus.op_b[SHW-1:0];
  assign is_funct = bus.alu_op == ALU_OP_FUNCT;
  assign m_enc    = bus.instr[25] && bus.instr[5];

  // Result-holding states accept too, so retire and accept can overlap
  assign out_valid = (state == SINGLE) || (state == DONE);
  assign in_ready  = (state == IDLE || out_valid)
                  && (!out_valid || bus.out_ready) && !flush;
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    dec     = AC_ADD;
    dec_ill = 1'b0;
    unique case (1'b1)
      bus.alu_op == ALU_OP_SUB: dec = AC_SUB;
      bus.alu_op == ALU_OP_ADD || bus.alu_op == ALU_OP_ADD2: dec = AC_ADD;
      is_funct && m_enc: begin
`ifdef MDU_EN
        dec = alu_ctrl_e'({2'b10, f3});
`else
        dec     = AC_AND;
        dec_ill = 1'b1;
`endif
      end
      is_funct && !m_enc: dec = funct_dec(f3, bus.instr[30], bus.instr[5]);
      default: dec = AC_ADD;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec)
      AC_AND:  alu_res = bus.op_a & bus.op_b;
      AC_OR:   alu_res = bus.op_a | bus.op_b;
      AC_XOR:  alu_res = bus.op_a ^ bus.op_b;
      AC_ADD:  alu_res = bus.op_a + bus.op_b;
      AC_SUB:  alu_res = bus.op_a - bus.op_b;
      AC_SLL:  alu_res = bus.op_a << shamt;
      AC_SRL:  alu_res = bus.op_a >> shamt;
      AC_SRA:  alu_res = $signed(bus.op_a) >>> shamt;
      AC_SLT:  alu_res[0] = $signed(bus.op_a) < $signed(bus.op_b);
      AC_SLTU: alu_res[0] = bus.op_a < bus.op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef MDU_EN
  logic            b_zero, ovf, is_div, div_special;
  logic [XLEN-1:0] div_res;

  assign is_div      = dec[4] && dec[2];
  assign b_zero      = bus.op_b == '0;
  assign ovf         = !dec[0] && (&bus.op_b)
                    && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}});
  assign div_special = is_div && (b_zero || ovf);
  // dec[1] picks the remainder flavour of the divide family
  assign div_res     = b_zero ? (dec[1] ? bus.op_a : '1)
                              : (dec[1] ? '0 : bus.op_a);
  assign go_mul      = dec[4] && !dec[2];
  assign go_div      = is_div && !div_special;
  assign single_res  = div_special ? div_res : alu_res;

  mdu_iter #(
    .XLEN      (XLEN),
    .MUL_RADIX (MUL_RADIX)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (accept && (go_mul || go_div)),
    .is_div (is_div),
    .fn     (dec[2:0]),
    .a      (bus.op_a),
    .b      (bus.op_b),
    .done   (mdu_done),
    .res    (mdu_res)
  );
`else
  assign go_mul     = 1'b0;
  assign go_div     = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_res    = '0;
  assign single_res = alu_res;
`endif

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, SINGLE, DONE: begin
          if (accept)
            state_nxt = go_mul ? MUL : (go_div ? DIV : SINGLE);
          else if (out_valid && bus.out_ready)
            state_nxt = IDLE;
          else if (state == SINGLE)
            state_nxt = DONE;
        end
        MUL, DIV: if (mdu_done) state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res_q  <= '0;
      ctrl_q <= AC_AND;
      ill_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ctrl_q <= dec;
        ill_q  <= dec_ill;
        if (!(go_mul || go_div))
          res_q <= dec_ill ? '0 : single_res;
      end else if (mdu_done && !flush) begin
        res_q <= mdu_res;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed + random ops against an arithmetic reference.
// Builds with or without MDU_EN; the reference follows the same switch.
module tb_alu_exec_ctrl;
  localparam int XLEN  = 32;
  localparam int RADIX = 1;
  localparam int MLAT  = 1 + XLEN / RADIX;
  localparam int DLAT  = 1 + XLEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.XLEN(XLEN)) bus();

  alu_exec_ctrl #(
    .XLEN      (XLEN),
    .MUL_RADIX (RADIX)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input bit b30,
                                     input bit b25, input bit b5);
    logic [31:0] i;
    i = $urandom;
    i[14:12] = f3;
    i[30] = b30;
    i[25] = b25;
    i[5] = b5;
    return i;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic void model(input logic [1:0] op, input logic [31:0] ins,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [4:0] c,
                                output logic ill, output int lat);
    logic [2:0]  f3;
    logic [4:0]  sh;
    logic [63:0] p;
    logic        ovf;
    f3 = ins[14:12];
    sh = b[4:0];
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; c = '0; ill = 1'b0; lat = 1; p = '0;
    if (op == 2'b01) begin
      c = 5'b00110; r = a - b;
    end else if (op != 2'b10) begin
      c = 5'b00010; r = a + b;
    end else if (ins[25] && ins[5]) begin
`ifdef MDU_EN
      c = {2'b10, f3};
      case (f3)
        3'd0: begin r = a * b; lat = MLAT; end
        3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; lat = MLAT; end
        3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; lat = MLAT; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; lat = MLAT; end
        3'd4: if (b == 0) r = '1; else if (ovf) r = a;
              else begin r = $signed(a) / $signed(b); lat = DLAT; end
        3'd5: if (b == 0) r = '1; else begin r = a / b; lat = DLAT; end
        3'd6: if (b == 0) r = a; else if (ovf) r = '0;
              else begin r = $signed(a) % $signed(b); lat = DLAT; end
        default: if (b == 0) r = a; else begin r = a % b; lat = DLAT; end
      endcase
`else
      ill = 1'b1;
`endif
    end else begin
      case (f3)
        3'd0: if (ins[30] && ins[5]) begin c = 5'b00110; r = a - b; end
              else begin c = 5'b00010; r = a + b; end
        3'd1: begin c = 5'b01001; r = a << sh; end
        3'd2: begin c = 5'b01000; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        3'd3: begin c = 5'b00101; r = (a < b) ? 32'd1 : 32'd0; end
        3'd4: begin c = 5'b00011; r = a ^ b; end
        3'd5: if (ins[30]) begin c = 5'b01010; r = 32'($signed(a) >>> sh); end
              else begin c = 5'b00100; r = a >> sh; end
        3'd6: begin c = 5'b00001; r = a | b; end
        default: begin c = 5'b00000; r = a & b; end
      endcase
    end
  endfunction

  task automatic drive(input logic [1:0] op, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    bus.alu_op = op;
    bus.instr = ins;
    bus.op_a = a;
    bus.op_b = b;
  endtask

  // Returns at the first negedge after the accepting posedge
  task automatic issue(input logic [1:0] op, input logic [31:0] ins,
                       input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    drive(op, ins, a, b);
    bus.in_valid = 1'b1;
    #1;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_rdy", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit rdy_seen);
    n = 1;
    rdy_seen = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready) rdy_seen = 1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string nm);
    logic [31:0] er;
    logic [4:0]  ec;
    logic        ei;
    int          el, n;
    bit          rdy_seen, bad;
    model(op, ins, a, b, er, ec, ei, el);
    issue(op, ins, a, b);
    wait_valid(n, rdy_seen);
    check({nm, "_lat"}, n, el);
    if (el > 1) check({nm, "_busy_rdy"}, rdy_seen, 0);
    check({nm, "_res"}, bus.result, er);
    check({nm, "_ctrl"}, bus.alu_ctrl, ec);
    check({nm, "_ill"}, bus.illegal, ei);
    bad = 0;
    repeat (hold) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.result !== er || bus.in_ready !== 1'b0)
        bad = 1;
    end
    if (hold > 0) check({nm, "_hold"}, bad, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({nm, "_retire"}, bus.out_valid, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] r1, r2, ins;
    logic [4:0]  c1, c2;
    logic        i1, i2;
    int          l1, l2, n;
    bit          rs, bad;
    logic [1:0]  op;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_ctrl", bus.alu_ctrl, 0);
    check("rst_ill", bus.illegal, 0);

    run_op(2'b00, $urandom, 32'd5, 32'd7, 0, "add");
    run_op(2'b10, mk(3'b101, 1, 0, 1), 32'h8000_0000, 32'd4, 0, "sra");
    run_op(2'b10, mk(3'b101, 0, 0, 1), 32'h8000_0000, 32'd4, 0, "srl");
    run_op(2'b10, mk(3'b000, 1, 0, 1), 32'd3, 32'd10, 0, "sub_f");
    run_op(2'b10, mk(3'b010, 0, 0, 1), 32'hFFFF_FFFF, 32'd1, 1, "slt");
    run_op(2'b10, mk(3'b011, 0, 1, 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
    run_op(2'b10, mk(3'b100, 0, 1, 1), 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'b10, mk(3'b111, 0, 1, 1), 32'd9, 32'd0, 0, "remu0");
    run_op(2'b10, mk(3'b100, 0, 1, 1), -32'sd7, 32'd2, 0, "div_neg");
    run_op(2'b10, mk(3'b000, 0, 1, 1), 32'd6, 32'd7, 0, "mul");

    // Hold the result 5 cycles, then retire and accept in the same cycle
    model(2'b10, 32'h0000_2033, 32'd2, 32'd9, r1, c1, i1, l1);
    ins = mk(3'b100, 0, 0, 1);
    model(2'b10, ins, 32'hF0F0, 32'h0FF0, r2, c2, i2, l2);
    issue(2'b10, 32'h0000_2033, 32'd2, 32'd9);
    wait_valid(n, rs);
    check("b2b_lat", n, l1);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.result !== r1 || bus.in_ready !== 1'b0)
        bad = 1;
    end
    check("b2b_hold", bad, 0);
    bus.out_ready = 1'b1;
    drive(2'b10, ins, 32'hF0F0, 32'h0FF0);
    bus.in_valid = 1'b1;
    #1;
    check("b2b_rdy", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_res", bus.result, r2);
    check("b2b_ctrl", bus.alu_ctrl, c2);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("b2b_retire", bus.out_valid, 0);

    // Flush with in_valid in the same cycle accepts nothing
    drive(2'b00, $urandom, 32'd1, 32'd1);
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_noacc", bus.out_valid, 0);

    // Flush drops a held result
    issue(2'b00, $urandom, 32'd4, 32'd4);
    wait_valid(n, rs);
    check("fhold_valid", bus.out_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fhold_drop", bus.out_valid, 0);

`ifdef MDU_EN
    issue(2'b10, mk(3'b101, 0, 1, 1), 32'hDEAD_BEEF, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fdiv_valid", bus.out_valid, 0);
    check("fdiv_ready", bus.in_ready, 1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) bad = 1;
    end
    check("fdiv_never", bad, 0);
`endif
    run_op(2'b00, $urandom, 32'd100, 32'd23, 0, "post_flush");

    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) op = 2'b10;
      run_op(op, $urandom, pick(), pick(), $urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
